// File: rtl/wb_intercon_if.sv
// Bus bundle between the d16 master, the wb_intercon interconnect and its slaves.
// Signal prefixes (i_/o_) are named from the interconnect's point of view.
interface wb_intercon_if #(
   parameter int NSLAVES = 2,
   parameter int AW      = 16,
   parameter int DW      = 16
);
   logic [AW-1:0]         i_m_addr;
   logic [DW-1:0]         i_m_dat;
   logic                  i_m_we;
   logic                  i_m_cyc;
   logic [DW-1:0]         o_m_dat;
   logic                  o_m_ack;
   logic                  o_m_err;
   logic [NSLAVES-1:0]    o_s_cyc;
   logic [AW-1:0]         o_s_addr;
   logic [DW-1:0]         o_s_dat;
   logic                  o_s_we;
   logic [NSLAVES*DW-1:0] i_s_dat;
   logic [NSLAVES-1:0]    i_s_ack;

   // Interconnect view: it is the slave of the master and drives the slave ports.
   modport slave (
      input  i_m_addr, i_m_dat, i_m_we, i_m_cyc, i_s_dat, i_s_ack,
      output o_m_dat, o_m_ack, o_m_err, o_s_cyc, o_s_addr, o_s_dat, o_s_we
   );

   modport master (
      output i_m_addr, i_m_dat, i_m_we, i_m_cyc, i_s_dat, i_s_ack,
      input  o_m_dat, o_m_ack, o_m_err, o_s_cyc, o_s_addr, o_s_dat, o_s_we
   );
endinterface

// File: rtl/wb_intercon.sv
// Single-master / N-slave interconnect: registered address decode, per-slave
// ack or auto-ack, bus-timeout watchdog and error reporting with fault capture.
module wb_intercon #(
   parameter int                      NSLAVES    = 2,
   parameter int                      AW         = 16,
   parameter int                      DW         = 16,
   parameter logic [NSLAVES*AW-1:0]   SLAVE_BASE = {16'hFF00, 16'h0000},
   parameter logic [NSLAVES*AW-1:0]   SLAVE_MASK = {16'hFFFE, 16'h8000},
   parameter logic [NSLAVES-1:0]      AUTO_ACK   = 2'b11,
   parameter int                      TIMEOUT    = 15,
   parameter int                      CW         = 8
) (
   input  logic                i_clk,
   input  logic                i_reset,
   wb_intercon_if.slave        bus,
   output logic [AW-1:0]       o_fault_addr,
   output logic [CW-1:0]       o_err_count
);
   localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t             r_state,      w_state;
   logic [WCW-1:0]     r_wcnt,       w_wcnt;
   logic [NSLAVES-1:0] r_s_cyc,      w_s_cyc;
   logic [AW-1:0]      r_s_addr,     w_s_addr;
   logic [DW-1:0]      r_s_dat,      w_s_dat;
   logic               r_s_we,       w_s_we;
   logic [DW-1:0]      r_m_dat,      w_m_dat;
   logic               r_m_ack,      w_m_ack;
   logic               r_m_err,      w_m_err;
   logic [AW-1:0]      r_fault_addr, w_fault_addr;
   logic [CW-1:0]      r_err_count,  w_err_count;

   logic [NSLAVES-1:0] w_dec_oh;
   logic               w_hit;
   logic [DW-1:0]      w_rdat;
   logic               w_ack;
   logic               w_timeout;
   logic [CW-1:0]      w_err_inc;

   // Address decode; a slave only claims the address if no lower index already did.
   always_comb begin
      w_hit    = 1'b0;
      w_dec_oh = '0;
      for (int i = 0; i < NSLAVES; i++) begin
         w_dec_oh[i] = ~w_hit &
                       ((bus.i_m_addr & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]);
         w_hit       = w_hit | w_dec_oh[i];
      end
   end

   // The latched one-hot select steers read data and ack; other slaves' acks fall out.
   always_comb begin
      w_rdat = '0;
      w_ack  = 1'b0;
      for (int i = 0; i < NSLAVES; i++) begin
         w_rdat = w_rdat | ({DW{r_s_cyc[i]}} & bus.i_s_dat[i*DW +: DW]);
         w_ack  = w_ack  | (r_s_cyc[i] & (AUTO_ACK[i] | bus.i_s_ack[i]));
      end
   end

   assign w_timeout = (TIMEOUT != 0) && (r_wcnt == WCW'(TIMEOUT));
   assign w_err_inc = (&r_err_count) ? r_err_count : r_err_count + CW'(1);

   always_comb begin
      w_state      = r_state;
      w_wcnt       = r_wcnt;
      w_s_cyc      = r_s_cyc;
      w_s_addr     = r_s_addr;
      w_s_dat      = r_s_dat;
      w_s_we       = r_s_we;
      w_m_dat      = r_m_dat;
      w_m_ack      = 1'b0;
      w_m_err      = 1'b0;
      w_fault_addr = r_fault_addr;
      w_err_count  = r_err_count;
      case (r_state)
         ST_IDLE: begin
            if (bus.i_m_cyc && w_hit) begin
               w_s_addr = bus.i_m_addr;
               w_s_dat  = bus.i_m_dat;
               w_s_we   = bus.i_m_we;
               w_s_cyc  = w_dec_oh;
               w_wcnt   = '0;
               w_state  = ST_ACTIVE;
            end else if (bus.i_m_cyc) begin
               w_m_err      = 1'b1;
               w_fault_addr = bus.i_m_addr;
               w_err_count  = w_err_inc;
               w_state      = ST_DONE;
            end else begin
               w_state = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            // A master abort wins over a same-cycle ack or timeout.
            if (!bus.i_m_cyc) begin
               w_s_cyc = '0;
               w_state = ST_IDLE;
            end else if (w_ack) begin
               w_m_dat = w_rdat;
               w_m_ack = 1'b1;
               w_s_cyc = '0;
               w_state = ST_DONE;
            end else if (w_timeout) begin
               w_m_err      = 1'b1;
               w_fault_addr = r_s_addr;
               w_err_count  = w_err_inc;
               w_s_cyc      = '0;
               w_state      = ST_DONE;
            end else begin
               w_wcnt = r_wcnt + WCW'(1);
            end
         end
         ST_DONE: begin
            if (!bus.i_m_cyc) begin
               w_state = ST_IDLE;
            end else begin
               w_state = ST_DONE;
            end
         end
         default: begin
            w_state = ST_IDLE;
            w_s_cyc = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= ST_IDLE;
         r_wcnt       <= '0;
         r_s_cyc      <= '0;
         r_s_addr     <= '0;
         r_s_dat      <= '0;
         r_s_we       <= 1'b0;
         r_m_dat      <= '0;
         r_m_ack      <= 1'b0;
         r_m_err      <= 1'b0;
         r_fault_addr <= '0;
         r_err_count  <= '0;
      end else begin
         r_state      <= w_state;
         r_wcnt       <= w_wcnt;
         r_s_cyc      <= w_s_cyc;
         r_s_addr     <= w_s_addr;
         r_s_dat      <= w_s_dat;
         r_s_we       <= w_s_we;
         r_m_dat      <= w_m_dat;
         r_m_ack      <= w_m_ack;
         r_m_err      <= w_m_err;
         r_fault_addr <= w_fault_addr;
         r_err_count  <= w_err_count;
      end
   end

   assign bus.o_m_dat  = r_m_dat;
   assign bus.o_m_ack  = r_m_ack;
   assign bus.o_m_err  = r_m_err;
   assign bus.o_s_cyc  = r_s_cyc;
   assign bus.o_s_addr = r_s_addr;
   assign bus.o_s_dat  = r_s_dat;
   assign bus.o_s_we   = r_s_we;
   assign o_fault_addr = r_fault_addr;
   assign o_err_count  = r_err_count;
endmodule
